// File: rtl/mem_copy_engine_if.sv
// Memory-side bus between the copy engine and the 32-entry data memory.
// master: engine (drives addr/wdata/read/write, consumes rdata).
// slave:  memory (consumes strobes, returns combinational rdata).
interface mem_copy_engine_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_read;
    logic          mem_write;
    logic [DW-1:0] mem_rdata;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_read,
        output mem_write,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_read,
        input  mem_write,
        output mem_rdata
    );
endinterface

// File: rtl/mem_copy_engine.sv
// Byte-wide copy (memmove) / fill sequencer for the data memory.
// Ports: clk, reset (sync, active-low), request inputs start/mode/
// src_addr/dst_addr/length/fill_value, memory bus via mem (master),
// status outputs busy/done/error/checksum.
module mem_copy_engine #(
    parameter int AW    = 8,
    parameter int DW    = 8,
    parameter int DEPTH = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                mode,
    input  logic [AW-1:0]       src_addr,
    input  logic [AW-1:0]       dst_addr,
    input  logic [5:0]          length,
    input  logic [DW-1:0]       fill_value,
    mem_copy_engine_if.master   mem,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [DW-1:0]       checksum
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_FILL  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [AW-1:0] src_q, src_d;
    logic [AW-1:0] dst_q, dst_d;
    logic [DW-1:0] fill_q, fill_d;
    logic [DW-1:0] hold_q, hold_d;
    logic [DW-1:0] checksum_q, checksum_d;
    logic [5:0]    off_q, off_d;
    logic [5:0]    rem_q, rem_d;
    logic          desc_q, desc_d;
    logic          error_q, error_d;

    // Range ends computed one bit wider than the address so that
    // base+length cannot wrap past DEPTH unnoticed.
    logic [AW:0] src_end;
    logic [AW:0] dst_end;
    logic        bad_req;
    logic        want_desc;

    always_comb begin
        src_end   = {1'b0, src_addr} + (AW+1)'(length);
        dst_end   = {1'b0, dst_addr} + (AW+1)'(length);
        bad_req   = (!mode && (src_end > (AW+1)'(DEPTH)))
                  || (dst_end > (AW+1)'(DEPTH));
        // Copying high-to-low when the destination is above the source
        // keeps overlapping ranges intact (memmove).
        want_desc = !mode && (dst_addr > src_addr);
    end

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        dst_d      = dst_q;
        fill_d     = fill_q;
        hold_d     = hold_q;
        checksum_d = checksum_q;
        off_d      = off_q;
        rem_d      = rem_q;
        desc_d     = desc_q;
        error_d    = error_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    src_d      = src_addr;
                    dst_d      = dst_addr;
                    fill_d     = fill_value;
                    rem_d      = length;
                    desc_d     = want_desc;
                    off_d      = want_desc ? (length - 6'd1) : 6'd0;
                    checksum_d = '0;
                    error_d    = 1'b0;
                    if (bad_req) begin
                        error_d = 1'b1;
                        state_d = S_DONE;
                    end else if (length == 6'd0) begin
                        state_d = S_DONE;
                    end else if (mode) begin
                        state_d = S_FILL;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ: begin
                hold_d  = mem.mem_rdata;
                state_d = S_WRITE;
            end
            S_WRITE, S_FILL: begin
                checksum_d = checksum_q
                           + ((state_q == S_FILL) ? fill_q : hold_q);
                rem_d      = rem_q - 6'd1;
                // Offset is frozen on the last byte so it never steps
                // outside 0..length-1.
                if (rem_q == 6'd1) begin
                    state_d = S_DONE;
                end else begin
                    off_d   = desc_q ? (off_q - 6'd1) : (off_q + 6'd1);
                    state_d = (state_q == S_FILL) ? S_FILL : S_READ;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            fill_q     <= '0;
            hold_q     <= '0;
            checksum_q <= '0;
            off_q      <= '0;
            rem_q      <= '0;
            desc_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            fill_q     <= fill_d;
            hold_q     <= hold_d;
            checksum_q <= checksum_d;
            off_q      <= off_d;
            rem_q      <= rem_d;
            desc_q     <= desc_d;
            error_q    <= error_d;
        end
    end

    always_comb begin
        mem.mem_addr  = '0;
        mem.mem_wdata = '0;
        mem.mem_read  = 1'b0;
        mem.mem_write = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        case (state_q)
            S_READ: begin
                mem.mem_addr = src_q + AW'(off_q);
                mem.mem_read = 1'b1;
                busy         = 1'b1;
            end
            S_WRITE: begin
                mem.mem_addr  = dst_q + AW'(off_q);
                mem.mem_wdata = hold_q;
                mem.mem_write = 1'b1;
                busy          = 1'b1;
            end
            S_FILL: begin
                mem.mem_addr  = dst_q + AW'(off_q);
                mem.mem_wdata = fill_q;
                mem.mem_write = 1'b1;
                busy          = 1'b1;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                done = 1'b0;
            end
        endcase
    end

    assign error    = error_q;
    assign checksum = checksum_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Scoreboard bench for mem_copy_engine with a 32-entry memory model.
// Expected writes and completions are queued at issue, checked by a monitor.
module tb_mem_copy_engine;

    logic       clk;
    logic       reset;
    logic       start;
    logic       mode;
    logic [7:0] src_addr;
    logic [7:0] dst_addr;
    logic [5:0] length;
    logic [7:0] fill_value;
    logic       busy;
    logic       done;
    logic       error;
    logic [7:0] checksum;

    mem_copy_engine_if #(.AW(8), .DW(8)) bus ();

    mem_copy_engine #(.AW(8), .DW(8), .DEPTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .mode       (mode),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .length     (length),
        .fill_value (fill_value),
        .mem        (bus),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .checksum   (checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] mem_arr [32];
    logic       mem_init;

    assign bus.mem_rdata = mem_arr[bus.mem_addr[4:0]];

    // Initial image: mem[i]=i below 16, 0x110-i from 16 up (20->FC, 31->F1).
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 32; i++)
                mem_arr[i] <= (i < 16) ? 8'(i) : 8'(272 - i);
        end else if (bus.mem_write) begin
            mem_arr[bus.mem_addr[4:0]] <= bus.mem_wdata;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;

    typedef struct {
        int         c;
        logic       err;
        logic [7:0] cks;
    } dn_t;

    wr_t wq[$];
    dn_t dq[$];

    int  n_chk  = 0;
    int  n_fail = 0;
    logic mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk("rw_exclusive", 32'(bus.mem_read & bus.mem_write), 0);
            if (!busy)
                chk("idle_bus",
                    {22'd0, bus.mem_read, bus.mem_write, bus.mem_addr}, 0);
            if (bus.mem_write) begin
                if (wq.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_write actual=%0d:%0h required=none",
                             bus.mem_addr, bus.mem_wdata);
                end else begin
                    wr_t w;
                    w = wq.pop_front();
                    chk("wr_addr", 32'(bus.mem_addr), 32'(w.a));
                    chk("wr_data", 32'(bus.mem_wdata), 32'(w.d));
                end
            end
            if (done) begin
                if (dq.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_done actual=cycle %0d required=none",
                             cyc);
                end else begin
                    dn_t e;
                    e = dq.pop_front();
                    chk("done_cycle", 32'(cyc), 32'(e.c));
                    chk("done_error", 32'(error), 32'(e.err));
                    chk("done_checksum", 32'(checksum), 32'(e.cks));
                end
            end
        end
    end

    task automatic pw(input logic [7:0] a, input logic [7:0] d);
        wq.push_back('{a: a, d: d});
    endtask

    // Called at a negedge in cycle 0; done expected k cycles later.
    task automatic go(input logic m, input logic [7:0] s,
                      input logic [7:0] d, input logic [5:0] l,
                      input logic [7:0] f, input int k,
                      input logic e, input logic [7:0] c,
                      input logic expect_done);
        if (expect_done)
            dq.push_back('{c: cyc + k, err: e, cks: c});
        mode       = m;
        src_addr   = s;
        dst_addr   = d;
        length     = l;
        fill_value = f;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 100 && dq.size() != 0; i++)
            @(negedge clk);
        chk(name, 32'(dq.size()), 0);
        chk({name, "_writes"}, 32'(wq.size()), 0);
        @(negedge clk);
    endtask

    initial begin
        reset      = 1'b0;
        mem_init   = 1'b1;
        start      = 1'b0;
        mode       = 1'b0;
        src_addr   = '0;
        dst_addr   = '0;
        length     = '0;
        fill_value = '0;
        repeat (3) @(negedge clk);
        mem_init = 1'b0;
        chk("reset_outs",
            {13'd0, busy, done, error, checksum, bus.mem_addr}, 0);
        reset  = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);

        // Fill 4 x AA at 16
        for (int i = 16; i < 20; i++) pw(8'(i), 8'hAA);
        go(1, 0, 16, 4, 8'hAA, 5, 0, 8'hA8, 1);
        wait_done("fill_done");
        for (int i = 16; i < 20; i++) chk("fill_mem", 32'(mem_arr[i]), 32'hAA);
        chk("fill_mem20", 32'(mem_arr[20]), 32'hFC);

        // Copy 0..2 -> 20..22 (dst above src: descending)
        pw(22, 2); pw(21, 1); pw(20, 0);
        go(0, 0, 20, 3, 0, 7, 0, 8'd3, 1);
        chk("copy_busy_c1", 32'(busy), 1);
        wait_done("copy_done");
        chk("copy_mem20", 32'(mem_arr[20]), 0);
        chk("copy_mem21", 32'(mem_arr[21]), 1);
        chk("copy_mem22", 32'(mem_arr[22]), 2);

        // Overlapping copy 2..5 -> 3..6
        pw(6, 5); pw(5, 4); pw(4, 3); pw(3, 2);
        go(0, 2, 3, 4, 0, 9, 0, 8'd14, 1);
        wait_done("ovl_done");
        for (int i = 3; i < 7; i++) chk("ovl_mem", 32'(mem_arr[i]), 32'(i - 1));
        chk("ovl_mem2", 32'(mem_arr[2]), 2);

        // Rejected request, error sticky
        go(0, 30, 0, 4, 0, 1, 1, 8'd0, 1);
        wait_done("rej_done");
        repeat (3) @(negedge clk);
        chk("rej_sticky", 32'(error), 1);

        // Zero length
        go(0, 4, 8, 0, 0, 1, 0, 8'd0, 1);
        wait_done("zero_done");
        chk("zero_error", 32'(error), 0);

        // Reset mid-copy 0..7 -> 24..31 (descending): two writes land
        pw(31, 7); pw(30, 5);
        go(0, 0, 24, 8, 0, 0, 0, 8'd0, 0);
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_outs",
            {11'd0, busy, done, error, bus.mem_read, bus.mem_write,
             checksum, bus.mem_addr}, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_writes", 32'(wq.size()), 0);
        chk("rst_mem31", 32'(mem_arr[31]), 7);
        chk("rst_mem30", 32'(mem_arr[30]), 5);
        chk("rst_mem29", 32'(mem_arr[29]), 32'hF3);
        chk("rst_mem24", 32'(mem_arr[24]), 32'hF8);

        // Overlapping ascending copy 10..12 -> 8..10
        pw(8, 10); pw(9, 11); pw(10, 12);
        go(0, 10, 8, 3, 0, 7, 0, 8'h21, 1);
        wait_done("asc_done");
        chk("asc_mem8", 32'(mem_arr[8]), 10);
        chk("asc_mem10", 32'(mem_arr[10]), 12);

        // Start while busy is ignored
        for (int i = 24; i < 30; i++) pw(8'(i), 8'h11);
        go(1, 0, 24, 6, 8'h11, 7, 0, 8'h66, 1);
        @(negedge clk);
        mode       = 1'b0;
        src_addr   = 8'd0;
        dst_addr   = 8'd1;
        length     = 6'd2;
        fill_value = 8'h55;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("busy_done");
        chk("busy_mem1", 32'(mem_arr[1]), 1);
        chk("busy_mem29", 32'(mem_arr[29]), 32'h11);

        repeat (2) @(negedge clk);
        chk("final_wq", 32'(wq.size()), 0);
        chk("final_dq", 32'(dq.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
